// File: rtl/mult_nxn_approx_ssd.sv
// Sequential radix-2 shift-add multiplier with optional approximate mode
// (operand LSBs truncated) and a multiplexed hex seven-segment display of
// the last completed product.
module mult_nxn_approx_ssd #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned APPROX_LSB = 2,
    parameter int unsigned REFRESH    = 10000,
    localparam int unsigned NDIG      = (2 * WIDTH + 3) / 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] m,
    output logic [NDIG-1:0]    digit,
    output logic [7:0]         seven_seg
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(REFRESH);
    localparam int unsigned IW = $clog2(NDIG);

    localparam logic [WIDTH-1:0] ApproxMask = {WIDTH{1'b1}} << APPROX_LSB;
    localparam logic [CW-1:0]    CntMax     = CW'(WIDTH - 1);
    localparam logic [RW-1:0]    RefMax     = RW'(REFRESH - 1);
    localparam logic [IW-1:0]    IdxMax     = IW'(NDIG - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    m_q, m_d;
    logic [RW-1:0]    refresh_q, refresh_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic [PW-1:0]    sum;
    logic [4*NDIG-1:0] m_ext;
    logic [3:0]       nib;

    assign op_a = mode ? (a & ApproxMask) : a;
    assign op_b = mode ? (b & ApproxMask) : b;
    // Partial product for the current multiplier bit (LSB of shifted copy).
    assign sum  = acc_q + (mplr_q[0] ? mcand_q : '0);

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign m    = m_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
        end
    end

    // FSM next-state and shift-add datapath.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, op_a};
                    mplr_d  = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    m_d     = sum;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Display scan registers, free-running regardless of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    // Refresh counter wrap advances the digit index.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == RefMax) begin
            refresh_d = '0;
            idx_d     = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
    end

    // Zero-extend so the top nibble is well defined for any width.
    assign m_ext = (4 * NDIG)'(m_q);

    // Digit enable and nibble select; index 0 shows the most significant nibble.
    always_comb begin
        nib   = '0;
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                nib      = m_ext[4*(NDIG-1-i) +: 4];
                digit[i] = 1'b1;
            end
        end
    end

    // Hex to active-high segments, dp always off.
    always_comb begin
        seven_seg = 8'h00;
        unique case (nib)
            4'h0: seven_seg = 8'h3F;
            4'h1: seven_seg = 8'h06;
            4'h2: seven_seg = 8'h5B;
            4'h3: seven_seg = 8'h4F;
            4'h4: seven_seg = 8'h66;
            4'h5: seven_seg = 8'h6D;
            4'h6: seven_seg = 8'h7D;
            4'h7: seven_seg = 8'h07;
            4'h8: seven_seg = 8'h7F;
            4'h9: seven_seg = 8'h6F;
            4'hA: seven_seg = 8'h77;
            4'hB: seven_seg = 8'h7C;
            4'hC: seven_seg = 8'h39;
            4'hD: seven_seg = 8'h5E;
            4'hE: seven_seg = 8'h79;
            4'hF: seven_seg = 8'h71;
            default: seven_seg = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mult_nxn_approx_ssd.sv
// Directed bench for mult_nxn_approx_ssd: WIDTH=8, APPROX_LSB=2, REFRESH=4.
module tb_mult_nxn_approx_ssd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a, b;
    logic        mode, start;
    logic        busy, done;
    logic [15:0] m;
    logic [3:0]  digit;
    logic [7:0]  seven_seg;

    int tests = 0;
    int fails = 0;

    mult_nxn_approx_ssd #(
        .WIDTH      (8),
        .APPROX_LSB (2),
        .REFRESH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .m         (m),
        .digit     (digit),
        .seven_seg (seven_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One multiply with full cycle-by-cycle protocol checks; operands are
    // scrambled mid-RUN to show the captured values are used.
    task automatic run_mul(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                           input logic tm, input logic [15:0] exp);
        @(negedge clk);
        a = ta; b = tb_; mode = tm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check({tag, ".busy"}, busy, 1);
            check({tag, ".nodone"}, done, 0);
            if (k == 3) begin
                a = ~ta; b = ~tb_; mode = ~tm;
            end
        end
        @(negedge clk);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_off"}, busy, 0);
        check({tag, ".m"}, m, exp);
        @(negedge clk);
        check({tag, ".done_off"}, done, 0);
        check({tag, ".m_hold"}, m, exp);
    endtask

    logic [7:0] segs [4];
    logic [3:0] prev;
    int         done_cnt, first_done, last_done, bad;
    logic [15:0] m_first, m_second;
    bit          synced;

    initial begin
        segs[0] = 8'h3F; segs[1] = 8'h3F; segs[2] = 8'h7F; segs[3] = 8'h71;
        rst_n = 1'b0; a = '0; b = '0; mode = 1'b0; start = 1'b0;
        #2;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.m", m, 0);
        check("rst.digit", digit, 4'b0001);
        check("rst.seg", seven_seg, 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul("exact", 8'd13, 8'd11, 1'b0, 16'h008F);
        run_mul("approx1", 8'd13, 8'd11, 1'b1, 16'h0060);
        run_mul("approx2", 8'd3, 8'd200, 1'b1, 16'h0000);
        run_mul("max", 8'd255, 8'd255, 1'b0, 16'hFE01);
        run_mul("zero", 8'd0, 8'h5A, 1'b0, 16'h0000);

        // Held start: results every 10 cycles, 5*7 then 6*7.
        @(negedge clk);
        a = 8'd5; b = 8'd7; mode = 1'b0; start = 1'b1;
        done_cnt = 0; first_done = 0; last_done = 0; m_first = '0; m_second = '0;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) a = 8'd6;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin first_done = k; m_first = m; end
                if (done_cnt == 2) m_second = m;
                last_done = k;
            end
        end
        start = 1'b0;
        check("held.count", done_cnt, 3);
        check("held.first", first_done, 9);
        check("held.last", last_done, 29);
        check("held.m1", m_first, 16'd35);
        check("held.m2", m_second, 16'd42);

        run_mul("disp_setup", 8'd13, 8'd11, 1'b0, 16'h008F);

        // Align to the start of slot 0, then verify four-cycle slots.
        synced = 1'b0;
        prev = digit;
        for (int k = 0; k < 64 && !synced; k++) begin
            @(negedge clk);
            if (prev == 4'b1000 && digit == 4'b0001) synced = 1'b1;
            prev = digit;
        end
        check("disp.sync", synced, 1);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                check($sformatf("disp.dig%0d_%0d", s, c), digit, 4'b0001 << (s % 4));
                check($sformatf("disp.seg%0d_%0d", s, c), seven_seg, segs[s % 4]);
            end
        end

        // Reset in the third RUN cycle.
        @(negedge clk);
        a = 8'd13; b = 8'd11; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstrun.busy", busy, 0);
        check("rstrun.done", done, 0);
        check("rstrun.m", m, 0);
        check("rstrun.digit", digit, 4'b0001);
        check("rstrun.seg", seven_seg, 8'h3F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("rstrun.quiet", bad, 0);

        // First start after reset is accepted at the first edge.
        a = 8'd2; b = 8'd3; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("post_rst.busy", busy, 1);
        synced = 1'b0;
        for (int k = 0; k < 12 && !synced; k++) begin
            @(negedge clk);
            if (done) synced = 1'b1;
        end
        check("post_rst.done", synced, 1);
        check("post_rst.m", m, 16'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
